// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Iterative restoring divider for the DIV/DIVU path. Retires one
//             quotient bit per clock; quotient goes to LO, remainder to HI.
//             Optional macro DIV_ZERO_FAST_EN: a divide-by-zero skips the
//             iteration phase and completes two cycles after acceptance.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int c_cnt_w = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;

   logic [WIDTH-1:0]   r_rem;        // partial remainder
   logic [WIDTH-1:0]   r_dvd;        // dividend magnitude, becomes quotient
   logic [WIDTH-1:0]   r_bmag;       // divisor magnitude
   logic [WIDTH-1:0]   r_araw;       // original dividend bits for div-by-zero
   logic               r_bzero;
   logic               r_qneg;
   logic               r_rneg;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_busy;
   logic               r_done;
   logic [WIDTH-1:0]   r_quotient;
   logic [WIDTH-1:0]   r_remainder;
   logic               r_dbz;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic               w_ge;

   // Operand magnitudes; the most negative value maps to itself as unsigned.
   assign w_a_neg = is_signed & a[WIDTH-1];
   assign w_b_neg = is_signed & b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -a : a;
   assign w_b_mag = w_b_neg ? -b : b;

   // One restoring step: shift in the next dividend bit, then trial-subtract.
   // The trial result's top bit doubles as the borrow (negative) indicator.
   assign w_shift = {r_rem, r_dvd[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_bmag};
   assign w_ge    = ~w_trial[WIDTH];

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef DIV_ZERO_FAST_EN
               w_next = (b == '0) ? S_FIX : S_RUN;
`else
               w_next = S_RUN;
`endif
            end
         end
         S_RUN:   if (r_cnt == c_cnt_w'(1)) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix-up and result hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem       <= '0;
         r_dvd       <= '0;
         r_bmag      <= '0;
         r_araw      <= '0;
         r_bzero     <= 1'b0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_cnt       <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_dvd   <= w_a_mag;
                  r_bmag  <= w_b_mag;
                  r_araw  <= a;
                  r_bzero <= (b == '0);
                  r_qneg  <= w_a_neg ^ w_b_neg;
                  r_rneg  <= w_a_neg;
                  r_rem   <= '0;
                  r_cnt   <= c_cnt_w'(WIDTH);
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               r_rem <= w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
               r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - c_cnt_w'(1);
            end
            S_FIX: begin
               if (r_bzero) begin
                  r_quotient  <= '1;
                  r_remainder <= r_araw;
                  r_dbz       <= 1'b1;
               end else begin
                  r_quotient  <= r_qneg ? -r_dvd : r_dvd;
                  r_remainder <= r_rneg ? -r_rem : r_rem;
                  r_dbz       <= 1'b0;
               end
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring divider for the MIPS DIV/DIVU path; the inverse of the partial-product multiplier datapath.
- Retires one quotient bit per clock.
- Result is written to the HI/LO pair: remainder goes to HI, quotient goes to LO.
- Sits beside the multiplier in the execute stage; the control unit stalls on busy and captures the result on done.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- a  input  WIDTH  dividend; captured on an accepted start.
- b  input  WIDTH  divisor; captured on an accepted start.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  single-cycle pulse; results are valid in that cycle.
- quotient  output  WIDTH  LO result; held until the next completion.
- remainder  output  WIDTH  HI result; held until the next completion.
- div_by_zero  output  1  flag for the last completed op; held with the results.

Behaviour:
- Reset: rst sampled high sets state to IDLE and clears busy, done, quotient, remainder, div_by_zero and the iteration counter to 0. This applies mid-operation; the in-flight op is abandoned with no done.

State IDLE:
- start=1 on an edge latches a, b and is_signed.
- Computes magnitudes: |x| when is_signed and the MSB is set, else x unchanged. Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
- Records quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a), both gated by is_signed.
- Clears the partial remainder, loads the counter with WIDTH, and moves to RUN.

State RUN, one step per cycle:
- Shift {rem, dvd} left by 1.
- trial = rem − |b|, computed at WIDTH+1 bits.
- If trial is non-negative: rem = trial and the new LSB of dvd = 1. Otherwise: rem unchanged and LSB = 0.
- Decrement the counter; after WIDTH steps, go to FIX.

State FIX (one cycle):
- quotient = dvd, negated if the quotient sign is set.
- remainder = rem, negated if the remainder sign is set.
- If b == 0: quotient = all ones, remainder = original a (raw bits), div_by_zero = 1. Otherwise div_by_zero = 0.
- Asserts done for exactly this cycle, then returns to IDLE.

Timing:
- start accepted at edge N: busy = 1 from edge N through edge N+WIDTH+1.
- done = 1 in the cycle following edge N+WIDTH+1, so latency is WIDTH+2 cycles (34 at the default).
- busy is 0 in the done cycle. A new start is accepted in that same cycle, back-to-back.

Boundary conditions:
- start while busy is ignored; operands are not re-latched.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_by_zero = 0.
- The remainder sign always follows the dividend (MIPS semantics), and |remainder| < |b|.
- Changes on a, b or is_signed after acceptance have no effect on the op in flight.

Optional Feature:
- Macro DIV_ZERO_FAST_EN.
- Defined: an accepted start with b == 0 skips RUN and goes directly to FIX. done pulses 2 cycles after acceptance, with the same result values as the full-latency case.
- Undefined: divide-by-zero takes the full WIDTH+2 latency, giving fixed timing for all ops.

Test Plan:
- DIVU a=100, b=7 → quotient 14, remainder 2, div_by_zero 0. done is exactly 34 cycles after start, and busy is high for 33 cycles.
- DIV a=0xFFFFFFF9 (−7), b=2 → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Repeat with a=7, b=0xFFFFFFFE → quotient 0xFFFFFFFD, remainder 1.
- DIV a=0x80000000, b=0xFFFFFFFF → quotient 0x80000000, remainder 0. DIVU with the same operands → quotient 0, remainder 0x80000000.
- DIVU a=5, b=0 → quotient 0xFFFFFFFF, remainder 5, div_by_zero 1. done is at 34 cycles with the macro undefined and at 2 cycles with DIV_ZERO_FAST_EN defined.
- Start a=0xFFFFFFFF, b=1; pulse start with a=9, b=3 at cycle 10 → result is still quotient 0xFFFFFFFF, remainder 0. A back-to-back start in the done cycle is then accepted and yields 3 / 0.
- Assert rst at cycle 15 of an op → done never pulses, and all outputs read 0 on the next cycle. A new start afterwards completes normally.
